// File: rtl/mem_access_stage.sv
// mem_access_stage
// -----------------------------------------------------------------------------
// MEM-stage controller sitting between EX/MEM and MEM/WB. A load or store in
// the stage becomes a single request/acknowledge transaction on the data
// memory bus. The block steers store data onto byte lanes, extracts and
// extends load data, and holds the pipeline in Stall until the access
// completes or times out.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   MemReadIn/WriteIn    load / store in stage (both set = store)
//   MemSizeIn            00 byte, 01 half, 10 word, 11 illegal
//   MemSignedIn          sign-extend (1) or zero-extend (0) loads
//   ALUResultIn          effective byte address
//   WriteDataIn          right-justified store data
//   MemReq/We/Addr/WData/Be  registered memory request
//   MemAck, MemRData     one-cycle completion pulse with read data
//   ReadData             registered, aligned and extended load result
//   Stall                freeze upstream stages, bubble MEM/WB
//   AddrErr              combinational misalignment / illegal size flag
//   BusErr               one-cycle pulse after a timed-out access
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  MemSizeIn,
  input  logic        MemSignedIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] WriteDataIn,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBe,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AddrErr,
  output logic        BusErr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        buserr_q, buserr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        load_q, load_d;

  logic        op;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign op = MemReadIn | MemWriteIn;

  always_comb begin
    AddrErr = 1'b0;
    if (op) begin
      case (MemSizeIn)
        2'b01:   AddrErr = ALUResultIn[0];
        2'b10:   AddrErr = (ALUResultIn[1:0] != 2'b00);
        2'b11:   AddrErr = 1'b1;
        default: AddrErr = 1'b0;
      endcase
    end
  end

  // Store lane steering: replicate narrow data across the word and let the
  // byte enables pick the lane. Loads always fetch the whole word.
  always_comb begin
    st_wdata = WriteDataIn;
    st_be    = 4'b1111;
    if (MemWriteIn) begin
      case (MemSizeIn)
        2'b00: begin
          st_wdata = {4{WriteDataIn[7:0]}};
          st_be    = 4'b0001 << ALUResultIn[1:0];
        end
        2'b01: begin
          st_wdata = {2{WriteDataIn[15:0]}};
          st_be    = ALUResultIn[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          st_wdata = WriteDataIn;
          st_be    = 4'b1111;
        end
      endcase
    end
  end

  // Load extraction uses the lane/size/sign captured at request time, since
  // MemAddr itself is word aligned.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = MemRData[7:0];
      2'd1:    ld_byte = MemRData[15:8];
      2'd2:    ld_byte = MemRData[23:16];
      default: ld_byte = MemRData[31:24];
    endcase
    ld_half = lane_q[1] ? MemRData[31:16] : MemRData[15:0];
    case (size_q)
      2'b00:   ld_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_ext = MemRData;
    endcase
  end

  // Transaction FSM: IDLE issues, BUSY waits for MemAck or timeout, DONE
  // releases the pipeline for exactly one cycle.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    buserr_d = 1'b0;
    cnt_d    = cnt_q;
    lane_d   = lane_q;
    size_d   = size_q;
    signed_d = signed_q;
    load_d   = load_q;
    Stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (op && !AddrErr) begin
          Stall    = 1'b1;
          req_d    = 1'b1;
          we_d     = MemWriteIn;
          addr_d   = {ALUResultIn[31:2], 2'b00};
          wdata_d  = st_wdata;
          be_d     = st_be;
          lane_d   = ALUResultIn[1:0];
          size_d   = MemSizeIn;
          signed_d = MemSignedIn;
          load_d   = ~MemWriteIn;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (MemAck) begin
          req_d   = 1'b0;
          if (load_q) begin
            rdata_d = ld_ext;
          end
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d    = 1'b0;
          buserr_d = 1'b1;
          rdata_d  = '0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      buserr_q <= 1'b0;
      cnt_q    <= '0;
      lane_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      load_q   <= load_d;
    end
  end

  assign MemReq   = req_q;
  assign MemWe    = we_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign MemBe    = be_q;
  assign ReadData = rdata_q;
  assign BusErr   = buserr_q;

endmodule
